calendar_cnt: RTL
=================

// Module: calendar_cnt
// PURPOSE
//  Keeps the current date: day, month, year offset and weekday.
//  Advances one day per day_tick_i and accepts a validated date load over a valid/ready handshake.
//  Sits upstream of the month/day pixel renderers; month_o drives their month index directly (0 = Jan).
//  Weekday is computed iteratively on load; no divider or multiplier.
// PARAMETERS
//  MONTH_CNT  12  months per year; MONTH_W = $clog2(MONTH_CNT)
//  YEAR_SPAN  100 years covered: offset 0..99 = 2000..2099; offset 0 is a leap year
//  RST_DAY    1   day of month after reset (1-based)
//  RST_MONTH  0   month after reset (0-based)
//  RST_YEAR   0   year offset after reset
//  RST_WDAY   5   weekday after reset (Mon=0 .. Sun=6); 5 matches 2000-01-01
// PORTS
//  clk_i           in   1        system clock
//  rst_i           in   1        reset, synchronous, active-low
//  day_tick_i      in   1        one-cycle pulse: advance one day
//  set_valid_i     in   1        load request; hold with data until accepted
//  set_ready_o     out  1        high only in IDLE; accept = valid & ready
//  set_day_i       in   5        day to load, 1..31
//  set_month_i     in   MONTH_W  month to load, 0..11
//  set_year_i      in   7        year offset to load, 0..99
//  set_err_o       out  1        one-cycle pulse: loaded date was invalid and is discarded
//  day_o           out  5        current day, 1-based
//  month_o         out  MONTH_W  current month, 0-based
//  year_o          out  7        current year offset
//  wday_o          out  3        current weekday, Mon=0
//  month_chg_o     out  1        one-cycle pulse when month_o changes (tick rollover or commit)
// BEHAVIOUR
//  Reset (rst_i==0 at a clk_i edge), in any state including mid-load:
//   - outputs take the RST_* values; FSM goes to IDLE.
//   - set_err_o, month_chg_o and the pending-tick flag clear; set_ready_o=1 after the edge.
//  Leap rule: leap = (year[1:0]==0).
//  Days-in-month (dim): 31/28|29/31/30/31/30/31/31/30/31/30/31.
//  Day tick in IDLE: registered outputs update at the next edge.
//   - day < dim: day+1.
//   - Else day=1 and month+1, with month_chg_o pulse.
//   - Month 11 rolls to month 0 and year+1; year 99 rolls to year 0.
//   - wday = (wday+1) mod 7, except on the year 99->0 wrap, where wday = RST_WDAY.
//  FSM: IDLE -> CHECK -> Y_ACC -> M_ACC -> COMMIT -> IDLE.
//   - Accept cycle T: latch set_* into shadow regs; go to CHECK.
//   - CHECK (T+1): invalid if month>11, year>99, day==0, or day>dim(month, year).
//     Invalid: set_err_o pulses on the edge leaving CHECK, next state IDLE, date unchanged.
//     Valid: acc=RST_WDAY, loop counter=0, next state Y_ACC.
//   - Y_ACC: one cycle per year offset below the loaded year: acc += (leap(y) ? 2 : 1) mod 7.
//     Zero cycles when year==0.
//   - M_ACC: one cycle per month below the loaded month: acc += dim(m) mod 7.
//     Zero cycles when month==0.
//   - COMMIT: outputs <= loaded date; wday <= (acc + day-1) mod 7.
//     month_chg_o pulses if the month differs from the old month.
//   - New values are visible from T+3+year+month. Worst case T+113.
//  Pending tick: a day_tick_i outside IDLE, or in the accept cycle, sets a 1-deep pending flag.
//   - Flag is applied in the first IDLE cycle, to whichever date is then current.
//   - set_ready_o stays low during that cycle; further ticks while pending are lost.
//  All arithmetic is mod 7 on 3-bit values; a sum of two values below 7 is reduced by one conditional subtract.
//  set_ready_o is registered, low from T+1 until back in IDLE.
// STRUCTURE
//  cal_pkg holds:
//   - MONTH_CNT, YEAR_SPAN, the dim table and the DIM_MOD7 table.
//   - function is_leap(), function days_in_month(month, leap), function add_mod7().
//   - typedef enum {IDLE, CHECK, Y_ACC, M_ACC, COMMIT} cal_state_t.
//  Sub-module cal_wday_calc holds the Y_ACC/M_ACC iterator with a start/done handshake.
//  calendar_cnt keeps the date registers, the tick logic and the top FSM.
// TESTING
//  1. Reset, no stimulus -> day 1, month 0, year 0, wday 5, set_ready_o=1, no pulses.
//  2. Load 2024-02-28 (24,1,28), then 2 ticks -> 02-29, then 03-01; month_chg_o on the second tick only.
//  3. Load 2023-02-29, or day 31 with month 3 -> set_err_o at T+2, date unchanged, ready again.
//  4. Load 2024-03-15 -> set_ready_o low T+1..T+28; at T+29 date 24/2/15, wday 4.
//  5. Load 2099-12-31 -> wday 3; one tick -> 2000-01-01, wday 5, month_chg_o=1.
//  6. Load 2024-02-28 with a tick at T+5 -> commits 02-28, next cycle 02-29.
//     Reset at T+10 instead -> RST_* values, no later commit.

Source files
------------

// File: rtl/cal_pkg.sv
// Calendar package: month/year geometry, day-count tables, mod-7 helpers
// and the load FSM state type shared by the calendar blocks.
package cal_pkg;

    localparam int MONTH_CNT = 12;
    localparam int YEAR_SPAN = 100;
    localparam int MONTH_W   = $clog2(MONTH_CNT);
    localparam int DAY_W     = 5;
    localparam int YEAR_W    = 7;

    // Days per month in a common year; February is patched for leap years.
    localparam logic [DAY_W-1:0] DIM_TAB [MONTH_CNT] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    // Same table reduced mod 7: how far the weekday moves across each month.
    localparam logic [2:0] DIM_MOD7 [MONTH_CNT] = '{
        3'd3, 3'd0, 3'd3, 3'd2, 3'd3, 3'd2,
        3'd3, 3'd3, 3'd2, 3'd3, 3'd2, 3'd3
    };

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        Y_ACC,
        M_ACC,
        COMMIT
    } cal_state_t;

    // 2000..2099 only: every fourth year starting at offset 0 is leap.
    function automatic logic is_leap(input logic [YEAR_W-1:0] year);
        return (year[1:0] == 2'b00);
    endfunction

    // Out-of-range months return 31 so callers never index past the table;
    // the load check rejects such months separately.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                       input logic leap);
        if (month >= MONTH_W'(MONTH_CNT)) return 5'd31;
        if ((month == MONTH_W'(1)) && leap) return 5'd29;
        return DIM_TAB[month];
    endfunction

    function automatic logic [2:0] dim_mod7(input logic [MONTH_W-1:0] month,
                                            input logic leap);
        if (month >= MONTH_W'(MONTH_CNT)) return 3'd0;
        if ((month == MONTH_W'(1)) && leap) return 3'd1;
        return DIM_MOD7[month];
    endfunction

    // Both operands are below 7, so one conditional subtract is enough.
    function automatic logic [2:0] add_mod7(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd7) s = s - 4'd7;
        return s[2:0];
    endfunction

    // Reduce a 5-bit value (at most 31) mod 7 with unrolled subtracts.
    function automatic logic [2:0] mod7_day(input logic [DAY_W-1:0] d);
        logic [DAY_W-1:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (r >= 5'd7) r = r - 5'd7;
        end
        return r[2:0];
    endfunction

endpackage

// File: rtl/calendar_cnt_if.sv
// Date-load handshake bundle: request, data, ready and error pulse.
interface calendar_cnt_if;

    logic                        set_valid_i;
    logic                        set_ready_o;
    logic [4:0]                  set_day_i;
    logic [cal_pkg::MONTH_W-1:0] set_month_i;
    logic [6:0]                  set_year_i;
    logic                        set_err_o;

    modport master (
        output set_valid_i, set_day_i, set_month_i, set_year_i,
        input  set_ready_o, set_err_o
    );

    modport slave (
        input  set_valid_i, set_day_i, set_month_i, set_year_i,
        output set_ready_o, set_err_o
    );

endinterface

// File: rtl/cal_wday_calc.sv
// Weekday iterator: walks the years then the months below the loaded date,
// accumulating the weekday shift mod 7 one step per cycle.
module cal_wday_calc
    import cal_pkg::*;
#(
    parameter int RST_WDAY = 5
) (
    input  logic               clk,
    input  logic               start,
    input  logic               y_step,
    input  logic               m_step,
    input  logic [YEAR_W-1:0]  year,
    input  logic [MONTH_W-1:0] month,
    output logic [2:0]         acc,
    output logic               y_done,
    output logic               m_done
);

    logic [YEAR_W-1:0] cnt;

    // The step that is active on the final year / final month.
    assign y_done = (cnt == (year - 7'd1));
    assign m_done = (cnt == (7'(month) - 7'd1));

    // Start seeds the accumulator with the weekday of 2000-01-01; each step
    // adds one year's or one month's shift, and the counter rewinds between phases.
    always_ff @(posedge clk) begin
        if (start) begin
            acc <= 3'(RST_WDAY);
            cnt <= '0;
        end else if (y_step) begin
            acc <= add_mod7(acc, is_leap(cnt) ? 3'd2 : 3'd1);
            cnt <= y_done ? '0 : cnt + 7'd1;
        end else if (m_step) begin
            acc <= add_mod7(acc, dim_mod7(cnt[MONTH_W-1:0], is_leap(year)));
            cnt <= cnt + 7'd1;
        end
    end

endmodule

// File: rtl/calendar_cnt.sv
// Calendar counter: holds day/month/year offset/weekday, advances on day
// ticks and loads a validated date through a multi-cycle weekday search.
module calendar_cnt
    import cal_pkg::*;
#(
    parameter int RST_DAY   = 1,
    parameter int RST_MONTH = 0,
    parameter int RST_YEAR  = 0,
    parameter int RST_WDAY  = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               day_tick_i,
    calendar_cnt_if.slave      set_if,
    output logic [4:0]         day_o,
    output logic [MONTH_W-1:0] month_o,
    output logic [6:0]         year_o,
    output logic [2:0]         wday_o,
    output logic               month_chg_o
);

    cal_state_t state_q, state_d;

    logic [DAY_W-1:0]   day_q;
    logic [MONTH_W-1:0] month_q;
    logic [YEAR_W-1:0]  year_q;
    logic [2:0]         wday_q;
    logic               ready_q, err_q, chg_q, pend_q;

    logic [DAY_W-1:0]   sh_day;
    logic [MONTH_W-1:0] sh_month;
    logic [YEAR_W-1:0]  sh_year;

    logic accept, load_ok, tick_now, pend_d, ready_d, chg_d;
    logic start, y_step, m_step, commit, err_set;
    logic y_done, m_done;
    logic [2:0] acc;
    logic [DAY_W-1:0] cur_dim, sh_dim;
    logic end_of_month, end_of_year, end_of_span;

    assign accept   = set_if.set_valid_i & ready_q;
    assign cur_dim  = days_in_month(month_q, is_leap(year_q));
    assign sh_dim   = days_in_month(sh_month, is_leap(sh_year));
    assign load_ok  = (sh_month <= MONTH_W'(MONTH_CNT - 1)) &&
                      (sh_year <= 7'(YEAR_SPAN - 1)) &&
                      (sh_day != '0) && (sh_day <= sh_dim);

    // A deferred tick wins the first idle cycle; ready is low then, so no accept can collide.
    assign tick_now     = (state_q == IDLE) && !accept && (pend_q || day_tick_i);
    assign end_of_month = (day_q >= cur_dim);
    assign end_of_year  = end_of_month && (month_q == MONTH_W'(MONTH_CNT - 1));
    assign end_of_span  = end_of_year && (year_q == 7'(YEAR_SPAN - 1));

    cal_wday_calc #(.RST_WDAY(RST_WDAY)) u_wday (
        .clk    (clk_i),
        .start  (start),
        .y_step (y_step),
        .m_step (m_step),
        .year   (sh_year),
        .month  (sh_month),
        .acc    (acc),
        .y_done (y_done),
        .m_done (m_done)
    );

    // Load FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Load FSM next state and per-state strobes; empty year/month phases are skipped.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        y_step  = 1'b0;
        m_step  = 1'b0;
        commit  = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = CHECK;
            end
            CHECK: begin
                if (!load_ok) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    start = 1'b1;
                    if (sh_year != '0)       state_d = Y_ACC;
                    else if (sh_month != '0) state_d = M_ACC;
                    else                     state_d = COMMIT;
                end
            end
            Y_ACC: begin
                y_step = 1'b1;
                if (y_done) state_d = (sh_month != '0) ? M_ACC : COMMIT;
            end
            M_ACC: begin
                m_step = 1'b1;
                if (m_done) state_d = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending flag: consumed in any idle non-accept cycle, armed by a tick elsewhere.
    always_comb begin
        pend_d = pend_q;
        if ((state_q == IDLE) && !accept) pend_d = 1'b0;
        else if (day_tick_i)              pend_d = 1'b1;
        ready_d = (state_d == IDLE) && !pend_d;
        chg_d   = (tick_now && end_of_month) || (commit && (sh_month != month_q));
    end

    // Handshake and pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            chg_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            err_q   <= err_set;
            chg_q   <= chg_d;
            pend_q  <= pend_d;
        end
    end

    // Shadow copy of the requested date, captured on the accept cycle.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            sh_day   <= set_if.set_day_i;
            sh_month <= set_if.set_month_i;
            sh_year  <= set_if.set_year_i;
        end
    end

    // Current date: commit of a loaded date, or one-day advance with rollovers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            day_q   <= 5'(RST_DAY);
            month_q <= MONTH_W'(RST_MONTH);
            year_q  <= 7'(RST_YEAR);
            wday_q  <= 3'(RST_WDAY);
        end else if (commit) begin
            day_q   <= sh_day;
            month_q <= sh_month;
            year_q  <= sh_year;
            wday_q  <= add_mod7(acc, mod7_day(sh_day - 5'd1));
        end else if (tick_now) begin
            wday_q <= end_of_span ? 3'(RST_WDAY) : add_mod7(wday_q, 3'd1);
            if (!end_of_month) begin
                day_q <= day_q + 5'd1;
            end else begin
                day_q <= 5'd1;
                if (end_of_year) begin
                    month_q <= '0;
                    year_q  <= end_of_span ? '0 : year_q + 7'd1;
                end else begin
                    month_q <= month_q + MONTH_W'(1);
                end
            end
        end
    end

    assign set_if.set_ready_o = ready_q;
    assign set_if.set_err_o   = err_q;
    assign day_o              = day_q;
    assign month_o            = month_q;
    assign year_o             = year_q;
    assign wday_o             = wday_q;
    assign month_chg_o        = chg_q;

endmodule
